// File: rtl/pebble_pkg.sv
// Shared types and widths for the Pebble run controller
// and the processor top it feeds.
package pebble_pkg;

    localparam int WORD_W = 9;
    localparam int ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE,
        TMO
    } run_state_t;

    function automatic logic is_rest(run_state_t s);
        return (s == IDLE) || (s == DONE) || (s == TMO);
    endfunction

endpackage

// File: rtl/pebble_run_ctl_if.sv
// Host word stream into the run controller
// (valid/ready with an end-of-program marker).
interface pebble_run_ctl_if #(
    parameter int W = pebble_pkg::WORD_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/pebble_cyc_cnt.sv
// Saturating up-counter with clear, enable and a
// reached-limit flag; clear+enable together loads 1.
module pebble_cyc_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    // next count: optional clear, then saturating increment
    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (en && (base != '1)) begin
            cnt_d = base + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign term  = (cnt_q >= limit);

endmodule

// File: rtl/pebble_run_ctl.sv
// Pebble run sequencer: load program, hold core in reset, start, time.
// Optional load checksum check: PEBBLE_RUN_CTL_CHECKSUM_EN.
module pebble_run_ctl #(
    parameter int WORD_W         = pebble_pkg::WORD_W,
    parameter int ADDR_W         = pebble_pkg::ADDR_W,
    parameter int IM_DEPTH       = 1024,
    parameter int CYC_W          = 16,
    parameter int TIMEOUT_CYCLES = 16'hFFFF,
    parameter int RST_HOLD       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_go,
    pebble_run_ctl_if.slave   host,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              proc_reset,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              busy,
    output logic              run_done,
    output logic              timeout,
    output logic              overflow,
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
    input  logic [WORD_W-1:0] exp_sum,
    output logic              csum_err,
`endif
    output logic [CYC_W-1:0]  run_cycles,
    output logic [ADDR_W:0]   words_loaded
);

    import pebble_pkg::*;

    localparam logic [CYC_W-1:0]  TMO_LIM  = CYC_W'(TIMEOUT_CYCLES);
    localparam logic [CYC_W-1:0]  HOLD_LIM = CYC_W'(RST_HOLD);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(IM_DEPTH - 1);

    run_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic              ovf_q, ovf_d;
    logic [CYC_W-1:0]  rc_q, rc_d;
    logic              cnt_clr, cnt_en, cnt_term;
    logic [CYC_W-1:0]  cnt_lim, cnt_val;
    logic              load_end;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d, sum_nx;
    logic [WORD_W-1:0] exp_q, exp_d;
    logic              cerr_q, cerr_d;
`endif

    pebble_cyc_cnt #(
        .W (CYC_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_lim),
        .count (cnt_val),
        .term  (cnt_term)
    );

    // sequencer next state, load datapath and sticky flags
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        words_d  = words_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        tmo_d    = tmo_q;
        ovf_d    = ovf_q;
        rc_d     = rc_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_lim  = TMO_LIM;
        load_end = 1'b0;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
        sum_d    = sum_q;
        sum_nx   = sum_q + host.in_data;
        exp_d    = exp_q;
        cerr_d   = cerr_q;
`endif
        unique case (state_q)
            IDLE, DONE, TMO: begin
                if (load_go) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    words_d = '0;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    ovf_d   = 1'b0;
                    rc_d    = '0;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
                    sum_d   = '0;
                    exp_d   = exp_sum;
                    cerr_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (host.in_valid) begin
                    we_d     = 1'b1;
                    waddr_d  = addr_q;
                    wdata_d  = host.in_data;
                    addr_d   = addr_q + 1'b1;
                    words_d  = words_q + 1'b1;
                    load_end = host.in_last || (addr_q == ADDR_END);
                    if (!host.in_last && (addr_q == ADDR_END)) begin
                        ovf_d = 1'b1;
                    end
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
                    sum_d = sum_nx;
                    if (load_end && (sum_nx != exp_q)) begin
                        cerr_d  = 1'b1;
                        state_d = TMO;
                    end else if (load_end) begin
                        state_d = HOLD;
                        cnt_clr = 1'b1;
                        cnt_en  = 1'b1;
                    end
`else
                    if (load_end) begin
                        state_d = HOLD;
                        cnt_clr = 1'b1;
                        cnt_en  = 1'b1;
                    end
`endif
                end
            end
            HOLD: begin
                cnt_en  = 1'b1;
                cnt_lim = HOLD_LIM;
                if (cnt_term) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (proc_done) begin
                    rc_d    = cnt_val;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_term) begin
                    tmo_d   = 1'b1;
                    state_d = TMO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rc_q    <= '0;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
            sum_q   <= '0;
            exp_q   <= '0;
            cerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            ovf_q   <= ovf_d;
            rc_q    <= rc_d;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
            sum_q   <= sum_d;
            exp_q   <= exp_d;
            cerr_q  <= cerr_d;
`endif
        end
    end

    assign host.in_ready = (state_q == LOAD);
    assign proc_reset    = (state_q != RUN);
    assign proc_start    = (state_q == RUN) && (cnt_val == CYC_W'(1));
    assign busy          = !is_rest(state_q);
    assign im_we         = we_q;
    assign im_waddr      = waddr_q;
    assign im_wdata      = wdata_q;
    assign run_done      = done_q;
    assign timeout       = tmo_q;
    assign overflow      = ovf_q;
    assign run_cycles    = rc_q;
    assign words_loaded  = words_q;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
    assign csum_err      = cerr_q;
`endif

endmodule

// File: tb/tb_pebble_run_ctl.sv
// Scoreboard bench for pebble_run_ctl: random programs vs a
// list-level model of writes, start time and final status.
module tb_pebble_run_ctl;

    localparam int TB_DEPTH = 8;
    localparam int TB_TMO   = 40;
    localparam int TB_HOLD  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_go = 1'b0;
    logic        im_we;
    logic [9:0]  im_waddr;
    logic [8:0]  im_wdata;
    logic        proc_reset;
    logic        proc_start;
    logic        proc_done = 1'b0;
    logic        busy;
    logic        run_done;
    logic        timeout;
    logic        overflow;
    logic        csum_err;
    logic [15:0] run_cycles;
    logic [10:0] words_loaded;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
    logic [8:0]  exp_sum = '0;
`else
    assign csum_err = 1'b0;
`endif

    pebble_run_ctl_if #(.W(9)) hif ();

    pebble_run_ctl #(
        .IM_DEPTH       (TB_DEPTH),
        .TIMEOUT_CYCLES (TB_TMO),
        .RST_HOLD       (TB_HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_go      (load_go),
        .host         (hif),
        .im_we        (im_we),
        .im_waddr     (im_waddr),
        .im_wdata     (im_wdata),
        .proc_reset   (proc_reset),
        .proc_start   (proc_start),
        .proc_done    (proc_done),
        .busy         (busy),
        .run_done     (run_done),
        .timeout      (timeout),
        .overflow     (overflow),
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
        .exp_sum      (exp_sum),
        .csum_err     (csum_err),
`endif
        .run_cycles   (run_cycles),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit busy_p = 1'b0;

    logic [18:0] wr_q [$];
    int          start_q [$];
    logic [32:0] st_q [$];
    logic [8:0]  prog [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] got,
                                logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    function automatic void fail(string nm);
        total++;
        bad++;
        $display("FAIL %s got=no_event exp=event", nm);
    endfunction

    function automatic logic [32:0] mk(bit ce, bit rd, bit tm,
                                       bit ov, int rc, int wl);
        return {ce, rd, tm, ov, 1'b1, 1'b0, 16'(rc), 11'(wl)};
    endfunction

    // monitor: pop and compare whenever the DUT presents an event
    always @(negedge clk) begin
        if (im_we) begin
            if (wr_q.size() == 0) fail("wr_unexpected");
            else chk("wr", {im_waddr, im_wdata}, wr_q.pop_front());
        end
        if (proc_start) begin
            if (start_q.size() == 0) fail("start_unexpected");
            else chk("start_cyc", cyc, start_q.pop_front());
        end
        if (busy_p && !busy) begin
            if (st_q.size() == 0) fail("status_unexpected");
            else chk("status",
                     {csum_err, run_done, timeout, overflow,
                      proc_reset, hif.in_ready, run_cycles,
                      words_loaded},
                     st_q.pop_front());
        end
        busy_p = busy;
    end

    task automatic chk_reset_outs();
        chk("rst_prst", proc_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", hif.in_ready, 0);
        chk("rst_we", {im_we, im_waddr, im_wdata}, 0);
        chk("rst_start", proc_start, 0);
        chk("rst_flags", {run_done, timeout, overflow, csum_err}, 0);
        chk("rst_cnts", {run_cycles, words_loaded}, 0);
    endtask

    // one program: load, optional run, status; delta!=0 breaks checksum
    task automatic run_case(input int n, input int done_n,
                            input int gap, input int gap_at,
                            input logic [8:0] delta);
        int acc, hs, k;
        logic [8:0] s;
        bit mism, rd, tm;
        int rc;
        acc = (n > TB_DEPTH) ? TB_DEPTH : n;
        s = '0;
        for (int i = 0; i < acc; i++) s = s + prog[i];
        mism = 1'b0;
`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
        mism = (delta != 0);
        exp_sum = s + delta;
`else
        if (delta != 0) mism = 1'b0;
`endif
        rd = 1'b0;
        tm = 1'b0;
        rc = 0;
        if (!mism) begin
            if (done_n >= 1 && done_n <= TB_TMO) begin
                rd = 1'b1;
                rc = done_n;
            end else begin
                tm = 1'b1;
            end
        end
        st_q.push_back(mk(mism, rd, tm, n > acc, rc, acc));
        @(negedge clk);
        load_go = 1'b1;
        @(negedge clk);
        load_go = 1'b0;
        hs = 0;
        for (int i = 0; i < acc; i++) begin
            if (i == gap_at) begin
                hif.in_valid = 1'b0;
                @(negedge clk);
            end
            while ($urandom_range(99) < gap) begin
                hif.in_valid = 1'b0;
                @(negedge clk);
            end
            hif.in_valid = 1'b1;
            hif.in_data  = prog[i];
            hif.in_last  = (i == n - 1);
            k = 0;
            while (!hif.in_ready && k < 8) begin
                @(negedge clk);
                k++;
            end
            if (!hif.in_ready) fail("hs_wait");
            wr_q.push_back({10'(i), prog[i]});
            hs = cyc;
            @(negedge clk);
        end
        hif.in_valid = 1'b0;
        hif.in_last  = 1'b0;
        if (n > acc) begin
            for (int j = 0; j < 2; j++) begin
                hif.in_valid = 1'b1;
                hif.in_data  = prog[acc];
                chk("ovf_rdy", hif.in_ready, 0);
                @(negedge clk);
            end
            hif.in_valid = 1'b0;
        end
        if (!mism) begin
            start_q.push_back(hs + TB_HOLD + 1);
            k = 0;
            while (!proc_start && k < 12) begin
                @(negedge clk);
                k++;
            end
            if (!proc_start) fail("start_wait");
            else begin
                chk("run_prst", proc_reset, 0);
                if (done_n > 0) begin
                    repeat (done_n - 1) @(negedge clk);
                    proc_done = 1'b1;
                    @(negedge clk);
                    proc_done = 1'b0;
                end
            end
        end
        k = 0;
        while (busy && k < TB_TMO + 20) begin
            @(negedge clk);
            k++;
        end
        if (busy) fail("idle_wait");
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        @(negedge clk);
        chk("late_done", {run_done, timeout, busy}, {rd, tm, 1'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dn;
        logic [8:0] dl;
        hif.in_valid = 1'b0;
        hif.in_data  = '0;
        hif.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs();

        prog = '{9'h101, 9'h0A2, 9'h033, 9'h1FF};
        run_case(4, 37, 0, 2, 9'h000);

        prog = '{9'h011, 9'h022, 9'h033};
        run_case(3, 0, 0, -1, 9'h000);

        prog.delete();
        for (int i = 0; i < 10; i++) prog.push_back(9'(i * 37 + 5));
        run_case(10, 5, 0, -1, 9'h000);

`ifdef PEBBLE_RUN_CTL_CHECKSUM_EN
        prog = '{9'h100, 9'h100};
        run_case(2, 6, 0, -1, 9'h001);
        run_case(2, 6, 0, -1, 9'h000);
`endif

        prog = '{9'h0AA, 9'h155, 9'h0F0};
        @(negedge clk);
        load_go = 1'b1;
        @(negedge clk);
        load_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hif.in_valid = 1'b1;
            hif.in_data  = prog[i];
            wr_q.push_back({10'(i), prog[i]});
            @(negedge clk);
        end
        hif.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        st_q.push_back(mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs();

        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(11, 1);
            prog.delete();
            for (int i = 0; i < n; i++)
                prog.push_back(9'($urandom_range(511)));
            dn = ($urandom_range(5) == 0) ? 0
                 : $urandom_range(TB_TMO + 4, 1);
            dl = ($urandom_range(3) == 0)
                 ? 9'($urandom_range(511, 1)) : 9'h000;
            run_case(n, dn, $urandom_range(40), -1, dl);
        end

        repeat (3) @(negedge clk);
        chk("wr_q_left", wr_q.size(), 0);
        chk("start_q_left", start_q.size(), 0);
        chk("st_q_left", st_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
